// File: rtl/complete_stage_pkg.sv
// complete_stage_pkg: types and constants shared by the complete stage and its selector.
//   PR              : physical-register tag width, taken from the global `PR define
//                     (falls back to 6 when the build does not provide one)
//   FU_STATE_PACKET : one flag per functional unit, alu_1 in the MSB, branch in the LSB
//   CDB_T_PACKET    : the three broadcast tags t0/t1/t2 (0 = slot unused)
//   fu_idx_e        : functional-unit name to bit position in FU_STATE_PACKET
`ifndef PR
`define PR 6
`endif

package complete_stage_pkg;

    localparam int unsigned PR       = `PR;
    localparam int unsigned NUM_FU   = 8;
    localparam int unsigned CDB_W    = 3;
    localparam int unsigned FU_IDX_W = 3;

    typedef enum logic [FU_IDX_W-1:0] {
        BRANCH      = 3'd0,
        MULT_2      = 3'd1,
        MULT_1      = 3'd2,
        STORELOAD_2 = 3'd3,
        STORELOAD_1 = 3'd4,
        ALU_3       = 3'd5,
        ALU_2       = 3'd6,
        ALU_1       = 3'd7
    } fu_idx_e;

    typedef struct packed {
        logic alu_1;
        logic alu_2;
        logic alu_3;
        logic storeload_1;
        logic storeload_2;
        logic mult_1;
        logic mult_2;
        logic branch;
    } FU_STATE_PACKET;

    typedef struct packed {
        logic [PR-1:0] t0;
        logic [PR-1:0] t1;
        logic [PR-1:0] t2;
    } CDB_T_PACKET;

    // Index of the set bit in a one-hot FU vector (0 when the vector is empty).
    function automatic logic [FU_IDX_W-1:0] onehot_to_idx(input logic [NUM_FU-1:0] oh);
        logic [FU_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (oh[i]) begin
                idx = idx | FU_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/complete_stage_cdb_select.sv
// cdb_select: combinational pick-up-to-3-of-8 priority selector.
//   req_i   : per-FU request vector
//   ptr_i   : highest-priority index; priority walks downward from here with wrap
//   gnt_o   : per-slot one-hot grant (slot 0 = highest priority winner)
//   gnt_v_o : per-slot grant valid
module cdb_select
    import complete_stage_pkg::*;
(
    input  logic [NUM_FU-1:0]             req_i,
    input  logic [FU_IDX_W-1:0]           ptr_i,
    output logic [CDB_W-1:0][NUM_FU-1:0]  gnt_o,
    output logic [CDB_W-1:0]              gnt_v_o
);

    // Walk the requesters from ptr_i downward, handing out slots in order.
    always_comb begin
        logic [FU_IDX_W-1:0] idx;
        logic [1:0]          slot;
        gnt_o   = '0;
        gnt_v_o = '0;
        slot    = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = ptr_i - FU_IDX_W'(k);
            if (req_i[idx] && (slot < 2'(CDB_W))) begin
                gnt_o[slot][idx] = 1'b1;
                gnt_v_o[slot]    = 1'b1;
                slot             = slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/complete_stage.sv
// complete_stage: per-FU one-entry hold registers feeding a 3-slot CDB broadcast.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   squash        : clears every hold register at the edge
//   fu_done       : per-FU result valid; fu_dest_pr: per-FU destination tag
//   cdb_t         : up to three broadcast tags this cycle (combinational)
//   fu_stall      : per-FU back-pressure, high while an entry cannot be freed (combinational)
// Build option: CDB_ROUND_ROBIN_EN selects a rotating priority pointer; otherwise
// alu_1 always has the highest priority and branch the lowest.
module complete_stage
    import complete_stage_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  FU_STATE_PACKET               fu_done,
    input  logic [NUM_FU-1:0][PR-1:0]    fu_dest_pr,
    output CDB_T_PACKET                  cdb_t,
    output FU_STATE_PACKET               fu_stall
);

    logic [NUM_FU-1:0]            hv_q, hv_d;
    logic [NUM_FU-1:0][PR-1:0]    hpr_q, hpr_d;
    logic [NUM_FU-1:0]            req, zero_tag, granted, freed, accept, done_vec;
    logic [CDB_W-1:0][NUM_FU-1:0] gnt;
    logic [CDB_W-1:0]             gnt_v;
    logic [FU_IDX_W-1:0]          ptr;
    logic [CDB_W-1:0][PR-1:0]     tag;

    assign done_vec = fu_done;

    // Tagged entries compete for a slot; zero-tag entries retire without one.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_req
        assign req[i]      = hv_q[i] && (hpr_q[i] != '0);
        assign zero_tag[i] = hv_q[i] && (hpr_q[i] == '0);
    end

    cdb_select u_cdb_select (
        .req_i   (req),
        .ptr_i   (ptr),
        .gnt_o   (gnt),
        .gnt_v_o (gnt_v)
    );

    assign granted = gnt[0] | gnt[1] | gnt[2];
    assign freed   = granted | zero_tag;
    // A freed entry may be refilled at the same edge: no bubble between results.
    assign accept  = done_vec & (~hv_q | freed);

    // Hold-register next state.
    always_comb begin
        hv_d  = (hv_q & ~freed) | accept;
        hpr_d = hpr_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[FU_IDX_W'(i)]) begin
                hpr_d[FU_IDX_W'(i)] = fu_dest_pr[FU_IDX_W'(i)];
            end
        end
    end

    // Hold registers; reset wins over squash, squash drops everything incoming.
    always_ff @(posedge clock) begin
        if (reset) begin
            hv_q  <= '0;
            hpr_q <= '0;
        end else if (squash) begin
            hv_q  <= '0;
        end else begin
            hv_q  <= hv_d;
            hpr_q <= hpr_d;
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [FU_IDX_W-1:0] ptr_q, ptr_d;

    // Next start is one below the lowest-priority winner of this cycle.
    always_comb begin
        ptr_d = ptr_q;
        for (int unsigned k = 0; k < CDB_W; k++) begin
            if (gnt_v[2'(k)]) begin
                ptr_d = onehot_to_idx(gnt[2'(k)]) - FU_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= FU_IDX_W'(ALU_1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = FU_IDX_W'(ALU_1);
`endif

    // Tag mux: OR of the granted entry's tag per slot.
    always_comb begin
        tag = '0;
        for (int unsigned k = 0; k < CDB_W; k++) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (gnt[2'(k)][FU_IDX_W'(i)]) begin
                    tag[2'(k)] = tag[2'(k)] | hpr_q[FU_IDX_W'(i)];
                end
            end
        end
    end

    // Outputs forced to zero while reset is held.
    always_comb begin
        cdb_t    = '0;
        fu_stall = '0;
        if (!reset) begin
            cdb_t.t0 = tag[0];
            cdb_t.t1 = tag[1];
            cdb_t.t2 = tag[2];
            fu_stall = hv_q & ~freed;
        end
    end

endmodule
